dmem_mmio: RTL and testbench
============================

// Module: dmem_mmio
// PURPOSE
//  Responder side of the pipeline's M-stage data-memory interface (memwrite/aluout/writedata -> readdata).
//  Word-addressed data RAM plus a small MMIO page: console TX FIFO, status, cycle counter, LED register.
//  Sits at the core top, beside instruction memory. Read is combinational, same cycle; the core has no stall path.
// PARAMETERS
//  RAM_WORDS   64   data RAM depth in 32-bit words (power of 2)
//  FIFO_DEPTH  8    console TX FIFO depth in bytes (power of 2, >=2)
// PORTS
//  clk       in   1   core clock; all state updates on rising edge
//  reset     in   1   asynchronous, active-low reset
//  we        in   1   write strobe (core memwriteM)
//  addr      in   32  byte address (core aluoutM); addr[1:0] ignored
//  wdata     in   32  write data (core writedataM)
//  rdata     out  32  read data (to core readdataM); combinational from addr
//  tx_valid  out  1   console FIFO non-empty
//  tx_data   out  8   FIFO head byte; valid while tx_valid
//  tx_ready  in   1   sink accepts head byte when tx_valid && tx_ready
//  leds      out  8   LED register
// BEHAVIOUR
//  Map: addr[31:16]==16'h0000 -> RAM, index addr[$clog2(RAM_WORDS)+1:2] (aliases wrap); addr[31:4]==28'hFFFF000 -> MMIO.
//   +0x0 CONSOLE_DATA  W: push wdata[7:0]; R: 0.
//   +0x4 STATUS  R: {29'b0, ovf, full, empty}; W (any value): clear ovf.
//   +0x8 CYCLES  R: counter; W: load wdata.
//   +0xC LEDS  R: {24'b0, leds}; W: leds <= wdata[7:0].
//   Unmapped: reads return 0, writes ignored.
//  Reads: rdata is purely combinational from addr and current state; a write in the same cycle is not visible until the next cycle.
//  Writes: take effect on the rising edge with we=1.
//  Reset (reset=0, async): FIFO empty (tx_valid=0, tx_data=0), ovf=0, counter=0, leds=0. RAM contents are not reset.
//  FIFO: push on CONSOLE_DATA write; pop on tx_valid&&tx_ready.
//   Push while full with no pop: byte dropped, ovf<=1 (sticky).
//   Push while full with a pop in the same cycle: accepted, count unchanged.
//   Push and pop while non-empty: both occur, count unchanged.
//   Pop while empty: impossible because tx_valid=0; ignored.
//   Pointers wrap modulo FIFO_DEPTH. full = count==FIFO_DEPTH; empty = count==0.
//   tx_data = head entry, registered storage, no output bubble.
//   ovf set and STATUS write in the same cycle: the set wins.
//  Counter: +1 every cycle; 32'hFFFF_FFFF wraps to 0. A CYCLES write loads wdata exactly; no increment that cycle.
//  Reset asserted mid-operation: queued bytes discarded immediately, tx_valid drops asynchronously.
// CONFIGURATION
//  DMEM_CYCLE_COUNTER_EN defined: the CYCLES register and its 32-bit counter are implemented as above.
//  Undefined: no counter flops; CYCLES reads 0 and writes are ignored. All other behaviour is identical.
// STRUCTURE
//  Package dmem_mmio_pkg: MMIO_BASE=32'hFFFF_0000; offsets OFF_CONSOLE/OFF_STATUS/OFF_CYCLES/OFF_LEDS;
//   STATUS bit indices ST_EMPTY=0, ST_FULL=1, ST_OVF=2; typedef enum region_e {REG_RAM, REG_MMIO, REG_NONE}.
//  Sub-module console_fifo (param DEPTH): push/din/full, pop/dout/empty, async active-low reset.
//  Top holds the RAM array, address decode, read mux, ovf, counter and leds.
// TESTING
//  1 Reset, then write 0xDEADBEEF @0x10 and read @0x10 -> rdata=0xDEADBEEF; read @0x14 in the same cycle -> its own contents.
//  2 Write 0x41,0x42,0x43 to 0xFFFF0000 with tx_ready=0 -> tx_valid=1, tx_data=0x41, STATUS=0x0;
//    then tx_ready=1 -> bytes 41,42,43 on consecutive cycles, then STATUS=0x1.
//  3 Push 9 bytes, tx_ready=0, DEPTH=8 -> STATUS=0x6 (ovf|full), 9th byte lost;
//    write STATUS -> 0x2; push while full with tx_ready=1 -> accepted, STATUS stays 0x2.
//  4 With the counter enabled, write 0xFFFFFFFE to 0xFFFF0008 -> reads 0xFFFFFFFE, then 0xFFFFFFFF, then 0x0.
//    With it disabled -> always 0.
//  5 Write 0x1A5 to 0xFFFF000C -> leds=0xA5, read=0xA5; read 0x80000000 -> 0; write there -> no state changes.
//  6 Assert reset mid-drain with 3 bytes queued -> tx_valid=0 immediately, leds=0, STATUS=0x1 after release.

Source files
------------

// File: rtl/dmem_mmio_pkg.sv
// Shared constants and address decode for the data-memory / MMIO responder.
package dmem_mmio_pkg;

  localparam logic [31:0] MMIO_BASE   = 32'hFFFF_0000;
  localparam logic [3:0]  OFF_CONSOLE = 4'h0;
  localparam logic [3:0]  OFF_STATUS  = 4'h4;
  localparam logic [3:0]  OFF_CYCLES  = 4'h8;
  localparam logic [3:0]  OFF_LEDS    = 4'hC;

  localparam int unsigned ST_EMPTY = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_OVF   = 2;

  typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_NONE} region_e;

  function automatic region_e decode_region(input logic [31:0] addr);
    if (addr[31:16] == 16'h0000) begin
      return REG_RAM;
    end else if (addr[31:4] == MMIO_BASE[31:4]) begin
      return REG_MMIO;
    end else begin
      return REG_NONE;
    end
  endfunction

endpackage

// File: rtl/dmem_mmio_console_fifo.sv
// Byte FIFO feeding the console sink; head entry is presented directly from storage.
module console_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  output logic       full,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = empty ? 8'h00 : mem_q[rptr_q];

  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM plus MMIO page (console FIFO, status, cycle counter, LEDs).
// Define DMEM_CYCLE_COUNTER_EN to build the CYCLES counter; otherwise CYCLES reads 0.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [7:0]  leds
);

  localparam int unsigned RAW = $clog2(RAM_WORDS);

  region_e     region;
  logic [3:0]  off;
  logic        mmio_wr, ram_wr;
  logic        push, pop, full, empty, ovf_set, status_wr;
  logic        ovf_q, ovf_d;
  logic [7:0]  leds_q, leds_d;
  logic [31:0] cycles_rd;
  logic [31:0] ram_q [RAM_WORDS];

  assign region  = decode_region(addr);
  assign off     = {addr[3:2], 2'b00};
  assign mmio_wr = we && (region == REG_MMIO);
  assign ram_wr  = we && (region == REG_RAM);

  assign push      = mmio_wr && (off == OFF_CONSOLE);
  assign status_wr = mmio_wr && (off == OFF_STATUS);
  assign pop       = tx_valid && tx_ready;
  assign ovf_set   = push && full && !pop;
  assign tx_valid  = !empty;
  assign leds      = leds_q;

  console_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .din   (wdata[7:0]),
    .full  (full),
    .pop   (pop),
    .dout  (tx_data),
    .empty (empty)
  );

  always_comb begin
    ovf_d  = ovf_q;
    leds_d = leds_q;
    // A dropped byte in the same cycle as a STATUS write keeps the flag set.
    if (status_wr) ovf_d = 1'b0;
    if (ovf_set)   ovf_d = 1'b1;
    if (mmio_wr && (off == OFF_LEDS)) leds_d = wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q  <= 1'b0;
      leds_q <= 8'h00;
    end else begin
      ovf_q  <= ovf_d;
      leds_q <= leds_d;
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q + 32'd1;
    if (mmio_wr && (off == OFF_CYCLES)) cycles_d = wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycles_q <= '0;
    else        cycles_q <= cycles_d;
  end

  assign cycles_rd = cycles_q;
`else
  assign cycles_rd = '0;
`endif

  always_ff @(posedge clk) begin
    if (ram_wr) ram_q[addr[RAW+1:2]] <= wdata;
  end

  always_comb begin
    rdata = '0;
    unique case (region)
      REG_RAM: rdata = ram_q[addr[RAW+1:2]];
      REG_MMIO: begin
        unique case (off)
          OFF_STATUS: begin
            rdata[ST_EMPTY] = empty;
            rdata[ST_FULL]  = full;
            rdata[ST_OVF]   = ovf_q;
          end
          OFF_CYCLES: rdata = cycles_rd;
          OFF_LEDS:   rdata = {24'h0, leds_q};
          default:    rdata = '0;
        endcase
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Randomised and directed checks of dmem_mmio against a queue/array reference model.
module tb_dmem_mmio;

  localparam int unsigned RAM_WORDS  = 64;
  localparam int unsigned FIFO_DEPTH = 8;
`ifdef DMEM_CYCLE_COUNTER_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic [7:0]  leds;

  always #5 clk = ~clk;

  dmem_mmio #(
    .RAM_WORDS  (RAM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .leds     (leds)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] m_ram   [RAM_WORDS];
  bit          m_known [RAM_WORDS];
  byte unsigned m_q[$];
  bit          m_ovf;
  logic [31:0] m_cnt;
  logic [7:0]  m_leds;

  logic [31:0] rd_seen;
  logic [7:0]  txd_seen;
  logic        txv_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // 0 = RAM, 1 = MMIO, 2 = unmapped
  function automatic int region_of(input logic [31:0] a);
    if (a[31:16] == 16'h0000) return 0;
    if (a[31:4] == 28'hFFFF000) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int rg = region_of(a);
    int off = int'(a[3:2]) * 4;
    int sz = m_q.size();
    if (rg == 0) return m_ram[a[7:2]];
    if (rg == 2) return 32'h0;
    case (off)
      4:  return {29'h0, m_ovf, sz == FIFO_DEPTH, sz == 0};
      8:  return CntEn ? m_cnt : 32'h0;
      12: return {24'h0, m_leds};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf  = 1'b0;
    m_cnt  = '0;
    m_leds = '0;
  endtask

  // Entered and left at a falling edge.
  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    int  sz, rg, off;
    bit  pop, push, set_ovf;
    we = w; addr = a; wdata = d; tx_ready = rdy;
    #1;
    rd_seen = rdata; txv_seen = tx_valid; txd_seen = tx_data;
    rg = region_of(a);
    if (!(rg == 0 && !m_known[a[7:2]])) chk("rdata", rdata, model_read(a));
    chk("tx_valid", tx_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("tx_data", tx_data, m_q[0]);
    chk("leds", leds, m_leds);
    @(posedge clk);
    sz      = m_q.size();
    off     = int'(a[3:2]) * 4;
    pop     = (sz != 0) && rdy;
    push    = w && rg == 1 && off == 0;
    set_ovf = push && sz == FIFO_DEPTH && !pop;
    if (pop) void'(m_q.pop_front());
    if (push && !set_ovf) m_q.push_back(d[7:0]);
    if (w && rg == 1 && off == 4) m_ovf = 1'b0;
    if (set_ovf) m_ovf = 1'b1;
    m_cnt = (w && rg == 1 && off == 8) ? d : m_cnt + 32'd1;
    if (w && rg == 1 && off == 12) m_leds = d[7:0];
    if (w && rg == 0) begin
      m_ram[a[7:2]]   = d;
      m_known[a[7:2]] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_leds", leds, 8'h00);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  drained [3];
    int          r;
    model_reset();
    for (int i = 0; i < RAM_WORDS; i++) m_known[i] = 1'b0;
    @(negedge clk);
    chk("reset_tx_valid", tx_valid, 1'b0);
    chk("reset_tx_data", tx_data, 8'h00);
    chk("reset_leds", leds, 8'h00);
    reset = 1'b1;

    for (int i = 0; i < RAM_WORDS; i++) step(1'b1, 32'(i * 4), $urandom, 1'b0);

    // RAM write then same-cycle-independent reads
    step(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    step(1'b0, 32'h10, 32'h0, 1'b0);
    chk("t1_rd10", rd_seen, 32'hDEADBEEF);
    step(1'b0, 32'h14, 32'h0, 1'b0);

    // Console FIFO fill and drain
    for (int i = 0; i < 3; i++) step(1'b1, 32'hFFFF_0000, 32'(8'h41 + i), 1'b0);
    step(1'b0, 32'hFFFF_0004, 32'h0, 1'b0);
    chk("t2_status_busy", rd_seen, 32'h0);
    chk("t2_head", txd_seen, 8'h41);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'hFFFF_0004, 32'h0, 1'b1);
      drained[i] = txd_seen;
    end
    chk("t2_byte0", drained[0], 8'h41);
    chk("t2_byte1", drained[1], 8'h42);
    chk("t2_byte2", drained[2], 8'h43);
    step(1'b0, 32'hFFFF_0004, 32'h0, 1'b0);
    chk("t2_status_empty", rd_seen, 32'h1);

    // Overflow, clear, push-while-full with pop
    for (int i = 0; i < 9; i++) step(1'b1, 32'hFFFF_0000, 32'(8'h60 + i), 1'b0);
    step(1'b0, 32'hFFFF_0004, 32'h0, 1'b0);
    chk("t3_status_ovf", rd_seen, 32'h6);
    step(1'b1, 32'hFFFF_0004, $urandom, 1'b0);
    step(1'b0, 32'hFFFF_0004, 32'h0, 1'b0);
    chk("t3_status_clr", rd_seen, 32'h2);
    step(1'b1, 32'hFFFF_0000, 32'h77, 1'b1);
    step(1'b0, 32'hFFFF_0004, 32'h0, 1'b0);
    chk("t3_status_full", rd_seen, 32'h2);
    for (int i = 0; i < FIFO_DEPTH; i++) step(1'b0, 32'hFFFF_0004, 32'h0, 1'b1);

    // Cycle counter wrap
    step(1'b1, 32'hFFFF_0008, 32'hFFFF_FFFE, 1'b0);
    step(1'b0, 32'hFFFF_0008, 32'h0, 1'b0);
    chk("t4_cyc0", rd_seen, CntEn ? 32'hFFFF_FFFE : 32'h0);
    step(1'b0, 32'hFFFF_0008, 32'h0, 1'b0);
    chk("t4_cyc1", rd_seen, CntEn ? 32'hFFFF_FFFF : 32'h0);
    step(1'b0, 32'hFFFF_0008, 32'h0, 1'b0);
    chk("t4_cyc2", rd_seen, 32'h0);

    // LEDs and unmapped space
    step(1'b1, 32'hFFFF_000C, 32'h1A5, 1'b0);
    step(1'b0, 32'hFFFF_000C, 32'h0, 1'b0);
    chk("t5_leds_rd", rd_seen, 32'hA5);
    chk("t5_leds_pin", leds, 8'hA5);
    step(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    step(1'b0, 32'h8000_0000, 32'h0, 1'b0);
    chk("t5_unmapped", rd_seen, 32'h0);
    chk("t5_leds_kept", leds, 8'hA5);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) step(1'b1, 32'hFFFF_0000, 32'(8'h30 + i), 1'b0);
    step(1'b0, 32'hFFFF_0004, 32'h0, 1'b1);
    do_reset();
    step(1'b0, 32'hFFFF_0004, 32'h0, 1'b0);
    chk("t6_status", rd_seen, 32'h1);
    chk("t6_leds", leds, 8'h00);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        a = {16'h0000, 16'($urandom)};
      end else if (r < 8) begin
        a = 32'hFFFF_0000 | 32'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) a[3:2] = 2'b00;
      end else begin
        a = $urandom;
        if (region_of(a) != 2) a[31:16] = 16'h1234;
      end
      step(1'($urandom), a, $urandom, $urandom_range(0, 2) == 0);
      if (n == 1500) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
